// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush control for the five-stage CPU core
//
// Merges per-stage stall requests into a 6-bit hold vector, turns a MEM-stage
// exception into a one-cycle flush plus redirect PC, and ignores all requests
// for the one cycle (SQUASH) that follows every flush.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (adds saturating perf counters).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stallreq_if/id/ex/mem    per-stage stall requests
//   excepttype_i             MEM-stage exception type, 0 = none
//   cp0_epc_i                current EPC, ERET target
//   stall[5:0]               hold: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   flush                    squash all pipeline registers this edge
//   new_pc                   redirect target while flush=1, else 0
//   squash_o                 high while in SQUASH state
//   perf_stall_cycles        stalled-edge count (PIPE_CTRL_PERF_EN only)
//   perf_flush_count         flush count (PIPE_CTRL_PERF_EN only)

module pipe_ctrl #(
    parameter logic [31:0] EBASE     = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE = 32'h0000_000e
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        squash_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are combinational so the pipeline registers see them at the
    // same edge. Reset forces every output low whatever the inputs are.
    always_comb begin
        state_next = state;
        stall      = 6'b000000;
        flush      = 1'b0;
        new_pc     = 32'h0000_0000;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (excepttype_i != 32'h0000_0000) begin
                        // Exception wins over any stall request; every
                        // non-ERET code, defined or not, vectors to EBASE.
                        flush      = 1'b1;
                        new_pc     = (excepttype_i == ERET_CODE) ? cp0_epc_i : EBASE;
                        state_next = SQUASH;
                    end else if (stallreq_mem) begin
                        stall = 6'b011111;
                    end else if (stallreq_ex) begin
                        stall = 6'b001111;
                    end else if (stallreq_id) begin
                        stall = 6'b000111;
                    end else if (stallreq_if) begin
                        stall = 6'b000011;
                    end
                end
                SQUASH: begin
                    // Requests now come from squashed instructions; drop them.
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // State is the register; the rst term keeps the output at its reset
    // value during the reset cycle even if reset arrives mid-SQUASH.
    assign squash_o = (state == SQUASH) && !rst;

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= 32'h0000_0000;
            perf_flush_count  <= 32'h0000_0000;
        end else begin
            if ((stall != 6'b000000) && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush && (perf_flush_count != 32'hFFFF_FFFF)) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule
